// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of a single 32-bit, 16K-word SPRAM bank: data port wins,
// fetch gets a slot after MAX_D_STREAK back-to-back data grants while it is waiting.
//
// Handshake: a requester holds *_req (and its address/controls) steady until it sees
// *_gnt high in the same cycle; read data comes back one cycle later with *_rvalid
// high for exactly one cycle, and *_rdata keeps showing that word until the next rvalid.
module spram_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        resetb,

    input  logic        i_req,
    input  logic [13:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [13:0] d_addr,
    input  logic [3:0]  d_ben,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [13:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_wen,
    output logic [3:0]  m_ben,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic [13:0] last_addr_q, last_addr_d;
    logic [31:0] i_hold_q, i_hold_d;
    logic [31:0] d_hold_q, d_hold_d;

    // Grants are suppressed during reset so no access (and no write) can start.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (resetb) begin
            if (d_req && !(i_req && (streak_q == MAX_S))) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_req || i_gnt) begin
            streak_d = 4'd0;
        end else if (d_gnt && (streak_q != MAX_S)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (i_gnt) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_DATA;
        end
    end

    always_comb begin
        last_addr_d = last_addr_q;
        if (i_gnt) begin
            last_addr_d = i_addr;
        end else if (d_gnt) begin
            last_addr_d = d_addr;
        end
    end

    // With no grant the SPRAM keeps seeing the last granted address.
    always_comb begin
        m_addr  = last_addr_d;
        m_wdata = d_wdata;
        m_wen   = d_gnt & d_we;
        m_ben   = (d_gnt & d_we) ? d_ben : 4'b0000;
    end

    always_comb begin
        i_rvalid = (owner_q == OWN_FETCH);
        d_rvalid = (owner_q == OWN_DATA);
        i_hold_d = i_rvalid ? m_rdata : i_hold_q;
        d_hold_d = d_rvalid ? m_rdata : d_hold_q;
        i_rdata  = i_hold_d;
        d_rdata  = d_hold_d;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            owner_q     <= OWN_NONE;
            streak_q    <= 4'd0;
            last_addr_q <= 14'd0;
            i_hold_q    <= 32'd0;
            d_hold_q    <= 32'd0;
        end else begin
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            last_addr_q <= last_addr_d;
            i_hold_q    <= i_hold_d;
            d_hold_q    <= d_hold_d;
        end
    end

endmodule
